// File: rtl/cpu_imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Optional trailing checksum stage is enabled by IMEM_LOADER_CHECKSUM_EN.
package cpu_imem_loader_pkg;

   typedef enum logic [2:0] {
      ST_CNT_LO  = 3'd0,
      ST_CNT_HI  = 3'd1,
      ST_DATA_LO = 3'd2,
      ST_DATA_HI = 3'd3,
      ST_CSUM    = 3'd4,
      ST_RUN     = 3'd5,
      ST_ERROR   = 3'd6
   } state_t;

   localparam int WIDTH_DEF       = 16;
   localparam int IADDR_WIDTH_DEF = 10;

   // Boot stream sends the low byte of each 16-bit quantity first.
   localparam bit BOOT_LO_FIRST = 1'b1;

   function automatic logic [15:0] join_bytes(input logic [7:0] first, input logic [7:0] second);
      return BOOT_LO_FIRST ? {second, first} : {first, second};
   endfunction

   // State entered once the last word (or an empty count) has been taken.
   function automatic state_t load_end_state();
`ifdef IMEM_LOADER_CHECKSUM_EN
      return ST_CSUM;
`else
      return ST_RUN;
`endif
   endfunction

endpackage

// File: rtl/cpu_imem_loader_ram.sv
// Simple dual-port program RAM: one write port, one registered read port (1-cycle latency).
// Only the read register is reset, so the array maps onto FPGA block RAM; read-during-write gives old data.
module imem_ram
   import cpu_imem_loader_pkg::*;
#(
   parameter int width      = WIDTH_DEF,
   parameter int addr_width = IADDR_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  we,
   input  logic [addr_width-1:0] waddr,
   input  logic [width-1:0]      wdata,
   input  logic [addr_width-1:0] raddr,
   output logic [width-1:0]      rdata
);

   logic [width-1:0] mem [0:(2**addr_width)-1];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rdata <= '0;
      end else begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/cpu_imem_loader.sv
// Boots the CPU program RAM from a byte stream while holding the CPU in reset, then releases it.
// rx_ready is high only while loading; trailing checksum byte enabled by IMEM_LOADER_CHECKSUM_EN.
module cpu_imem_loader
   import cpu_imem_loader_pkg::*;
#(
   parameter int width       = WIDTH_DEF,
   parameter int iaddr_width = IADDR_WIDTH_DEF
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [7:0]             rx_data,
   input  logic                   rx_valid,
   output logic                   rx_ready,
   input  logic                   boot_req,
   input  logic [iaddr_width-1:0] iaddr,
   output logic [width-1:0]       idata,
   output logic                   cpu_reset,
   output logic                   done,
   output logic                   error
);

   localparam logic [31:0]          DEPTH    = 32'd1 << iaddr_width;
   localparam logic [iaddr_width:0] ONE      = 1;
   localparam state_t               LOAD_END = load_end_state();

   state_t                 state;
   logic [iaddr_width:0]   count;
   logic [iaddr_width:0]   waddr;
   logic [iaddr_width:0]   waddr_inc;
   logic [7:0]             lo_byte;
   logic [15:0]            n_word;
   logic                   n_too_big;
   logic                   last_word;
   logic                   xfer;
   logic                   we;
   logic [width-1:0]       wdata;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]             csum;
`endif

   assign xfer      = rx_valid & rx_ready;
   // The low-byte latch doubles as holder for the count's first byte.
   assign n_word    = join_bytes(lo_byte, rx_data);
   assign n_too_big = {16'd0, n_word} > DEPTH;
   assign waddr_inc = waddr + ONE;
   assign last_word = (waddr_inc == count);
   assign we        = xfer && (state == ST_DATA_HI);
   assign wdata     = width'(join_bytes(lo_byte, rx_data));

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= ST_CNT_LO;
         rx_ready  <= 1'b1;
         cpu_reset <= 1'b1;
         done      <= 1'b0;
         error     <= 1'b0;
         count     <= '0;
         waddr     <= '0;
         lo_byte   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum      <= '0;
`endif
      end else begin
         case (state)
            ST_CNT_LO: begin
               if (xfer) begin
                  lo_byte <= rx_data;
                  state   <= ST_CNT_HI;
               end
            end
            ST_CNT_HI: begin
               if (xfer) begin
                  count <= n_word[iaddr_width:0];
                  waddr <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum  <= '0;
`endif
                  if (n_too_big) begin
                     state    <= ST_ERROR;
                     rx_ready <= 1'b0;
                     error    <= 1'b1;
                  end else if (n_word == 16'd0) begin
                     state     <= LOAD_END;
                     rx_ready  <= (LOAD_END == ST_CSUM);
                     cpu_reset <= (LOAD_END != ST_RUN);
                     done      <= (LOAD_END == ST_RUN);
                  end else begin
                     state <= ST_DATA_LO;
                  end
               end
            end
            ST_DATA_LO: begin
               if (xfer) begin
                  lo_byte <= rx_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum    <= csum ^ rx_data;
`endif
                  state   <= ST_DATA_HI;
               end
            end
            ST_DATA_HI: begin
               if (xfer) begin
                  waddr <= waddr_inc;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum  <= csum ^ rx_data;
`endif
                  if (last_word) begin
                     state     <= LOAD_END;
                     rx_ready  <= (LOAD_END == ST_CSUM);
                     cpu_reset <= (LOAD_END != ST_RUN);
                     done      <= (LOAD_END == ST_RUN);
                  end else begin
                     state <= ST_DATA_LO;
                  end
               end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CSUM: begin
               if (xfer) begin
                  rx_ready <= 1'b0;
                  if (rx_data == csum) begin
                     state     <= ST_RUN;
                     cpu_reset <= 1'b0;
                     done      <= 1'b1;
                  end else begin
                     state <= ST_ERROR;
                     error <= 1'b1;
                  end
               end
            end
`endif
            ST_RUN, ST_ERROR: begin
               if (boot_req) begin
                  state     <= ST_CNT_LO;
                  rx_ready  <= 1'b1;
                  cpu_reset <= 1'b1;
                  done      <= 1'b0;
                  error     <= 1'b0;
                  waddr     <= '0;
                  count     <= '0;
               end
            end
            default: begin
               state     <= ST_ERROR;
               rx_ready  <= 1'b0;
               cpu_reset <= 1'b1;
               done      <= 1'b0;
               error     <= 1'b1;
            end
         endcase
      end
   end

   imem_ram #(
      .width      (width),
      .addr_width (iaddr_width)
   ) u_ram (
      .clk     (clk),
      .reset_n (reset_n),
      .we      (we),
      .waddr   (waddr[iaddr_width-1:0]),
      .wdata   (wdata),
      .raddr   (iaddr),
      .rdata   (idata)
   );

endmodule
